ct_ciu_age_arb: RTL and testbench
=================================

// Module: ct_ciu_age_arb
// PURPOSE
//  Self-maintaining age-matrix arbiter for CIU buffers (SNB/SAB class). Tracks allocation order of DEPTH
//  entries in an internal age matrix and grants the oldest entry with a pending request via a registered
//  valid/ready output stage. Replaces per-entry age-vector inputs plus combinational oldest-select.
// PARAMETERS
//  DEPTH   24  number of tracked entries (2..64)
//  IDX_W   5   width of binary grant index; must satisfy 2**IDX_W >= DEPTH
// PORTS
//  ciuclk            in   1        clock
//  cpurst_b          in   1        synchronous active-low reset
//  alloc_vld         in   1        allocate entry alloc_idx this cycle
//  alloc_idx         in   IDX_W    entry being allocated
//  dealloc_vec       in   DEPTH    entries freed this cycle (any number of bits)
//  req_vld           in   DEPTH    per-entry request; masked by internal entry_vld
//  gnt_vld           out  1        grant valid
//  gnt_oh            out  DEPTH    one-hot granted entry
//  gnt_idx           out  IDX_W    binary granted entry
//  gnt_rdy           in   1        consumer accepts grant
//  entry_vld         out  DEPTH    allocated-entry vector
//  empty             out  1        entry_vld == 0
//  full              out  1        entry_vld all ones
// BEHAVIOUR
//  - Reset (cpurst_b=0 at posedge): entry_vld, age matrix, gnt_vld, gnt_oh, gnt_idx all 0; empty=1, full=0.
//  - Age matrix age[i][j]=1 <=> entry j older than i; diagonal always 0.
//  - Alloc of i: entry_vld[i]<=1; age[i][j]<=entry_vld[j] & ~dealloc_vec[j] (j!=i); age[j][i]<=0 for all j.
//  - Dealloc of i: entry_vld[i]<=0; row i and column i cleared.
//  - Alloc and dealloc of the same entry in one cycle: alloc wins (entry becomes youngest valid).
//  - Alloc of an already-valid entry: re-allocation; entry becomes youngest; no error.
//  - Eligible: elig[i]=req_vld[i] & entry_vld[i] & ~mask[i]; pick[i]=elig[i] & ~|(elig & age[i]).
//    At most one pick bit set by construction.
//  - Output stage: if !gnt_vld | gnt_rdy, load gnt_vld<=|pick, gnt_oh<=pick, gnt_idx<=enc(pick) next
//    cycle (1-cycle latency request->grant). While gnt_vld & !gnt_rdy, gnt_* hold stable.
//  - mask: entry held in gnt_oh is masked from pick while gnt_vld (no double grant). Requester must drop
//    req_vld[i] the cycle after acceptance; it may re-request later.
//  - Dealloc of an entry held in a pending grant: grant stays valid until accepted (consumer discards).
//  - Simultaneous alloc, dealloc, accept and new pick in one cycle are all legal; all updates use
//    current-cycle state.
//  - gnt_idx is zero-extended; bits >= DEPTH never set.
//  - Full/empty: combinational from entry_vld. No alloc blocking; upstream honours full.
// CONFIGURATION
//  CT_CIU_AGE_ARB_PERF_EN defined: adds output perf_conflict_cnt [15:0], which increments once per cycle in
//    which >=2 eligible entries exist and the output stage loads. It saturates at 16'hFFFF and resets to 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset, then alloc 3,7,1 in consecutive cycles; req_vld=all ones -> grants 3,7,1 in that order,
//     with gnt_rdy=1 and each entry's req dropped after acceptance.
//  2. DEPTH=24: fill 0..23 -> full=1. Dealloc 5 and alloc 5 in the same cycle -> 5 is the youngest valid
//     entry and full stays 1.
//  3. Hold gnt_rdy=0 for 4 cycles with gnt_oh=bit2 -> gnt_* stable, entry 2 not re-picked; raise
//     gnt_rdy -> next-oldest requester granted in the following cycle.
//  4. Allocate entries in order 0,1,2 (0 oldest); only req_vld[2]=1 -> grant 2. Then raise req_vld[0] ->
//     grant 0 wins over 2 on the next pick.
//  5. Assert reset mid-grant (gnt_vld=1) -> next cycle gnt_vld=0, entry_vld=0, empty=1.
//  6. PERF_EN: 3 requesters for 10 cycles with gnt_rdy=1 -> perf_conflict_cnt counts only cycles with
//     >=2 eligible; preload near saturation -> holds at 16'hFFFF.

Source files
------------

// File: rtl/ct_ciu_age_arb.sv
// Age-matrix arbiter: tracks allocation order of DEPTH entries and grants the oldest requester
// through a registered valid/ready stage. Define CT_CIU_AGE_ARB_PERF_EN to add perf_conflict_cnt.
module ct_ciu_age_arb #(
   parameter int unsigned DEPTH = 24,
   parameter int unsigned IDX_W = 5
) (
   input  logic             ciuclk,
   input  logic             cpurst_b,
   input  logic             alloc_vld,
   input  logic [IDX_W-1:0] alloc_idx,
   input  logic [DEPTH-1:0] dealloc_vec,
   input  logic [DEPTH-1:0] req_vld,
   output logic             gnt_vld,
   output logic [DEPTH-1:0] gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   input  logic             gnt_rdy,
   output logic [DEPTH-1:0] entry_vld,
   output logic             empty,
   output logic             full
`ifdef CT_CIU_AGE_ARB_PERF_EN
   ,
   output logic [15:0]      perf_conflict_cnt
`endif
);

   logic [DEPTH-1:0]            entry_vld_q, entry_vld_d;
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
   logic                        gnt_vld_q, gnt_vld_d;
   logic [DEPTH-1:0]            gnt_oh_q, gnt_oh_d;
   logic [IDX_W-1:0]            gnt_idx_q, gnt_idx_d;

   logic [DEPTH-1:0]            alloc_oh_c;
   logic [DEPTH-1:0]            mask_c;
   logic [DEPTH-1:0]            elig_c;
   logic [DEPTH-1:0]            pick_c;
   logic [IDX_W-1:0]            pick_idx_c;
   logic                        load_c;

   // Decode the allocation index; out-of-range indices allocate nothing.
   always_comb begin
      alloc_oh_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (alloc_vld && (alloc_idx == IDX_W'(i))) begin
            alloc_oh_c[i] = 1'b1;
         end
      end
   end

   // Entry valid and age matrix next state; alloc overrides a same-cycle dealloc of that entry.
   always_comb begin
      entry_vld_d = (entry_vld_q & ~dealloc_vec) | alloc_oh_c;
      age_d       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (i == j) begin
               age_d[i][j] = 1'b0;
            end else if (alloc_oh_c[i]) begin
               age_d[i][j] = entry_vld_q[j] & ~dealloc_vec[j];
            end else if (alloc_oh_c[j] || dealloc_vec[i] || dealloc_vec[j]) begin
               age_d[i][j] = 1'b0;
            end else begin
               age_d[i][j] = age_q[i][j];
            end
         end
      end
   end

   // Oldest eligible entry: no other eligible entry is older than it.
   always_comb begin
      mask_c     = gnt_vld_q ? gnt_oh_q : '0;
      elig_c     = req_vld & entry_vld_q & ~mask_c;
      pick_c     = '0;
      pick_idx_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         pick_c[i] = elig_c[i] & ~(|(elig_c & age_q[i]));
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (pick_c[i]) begin
            pick_idx_c = pick_idx_c | IDX_W'(i);
         end
      end
   end

   // Output stage loads when empty or when the held grant is accepted.
   always_comb begin
      load_c    = ~gnt_vld_q | gnt_rdy;
      gnt_vld_d = gnt_vld_q;
      gnt_oh_d  = gnt_oh_q;
      gnt_idx_d = gnt_idx_q;
      if (load_c) begin
         gnt_vld_d = |pick_c;
         gnt_oh_d  = pick_c;
         gnt_idx_d = pick_idx_c;
      end
   end

   always_ff @(posedge ciuclk) begin
      if (!cpurst_b) begin
         entry_vld_q <= '0;
         age_q       <= '0;
         gnt_vld_q   <= 1'b0;
         gnt_oh_q    <= '0;
         gnt_idx_q   <= '0;
      end else begin
         entry_vld_q <= entry_vld_d;
         age_q       <= age_d;
         gnt_vld_q   <= gnt_vld_d;
         gnt_oh_q    <= gnt_oh_d;
         gnt_idx_q   <= gnt_idx_d;
      end
   end

`ifdef CT_CIU_AGE_ARB_PERF_EN
   logic [15:0] perf_cnt_q, perf_cnt_d;
   logic        conflict_c;

   // A conflict is a loading cycle with two or more eligible entries; saturates at all ones.
   always_comb begin
      conflict_c = |(elig_c & (elig_c - DEPTH'(1)));
      perf_cnt_d = perf_cnt_q;
      if (load_c && conflict_c && (perf_cnt_q != 16'hFFFF)) begin
         perf_cnt_d = perf_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge ciuclk) begin
      if (!cpurst_b) begin
         perf_cnt_q <= 16'd0;
      end else begin
         perf_cnt_q <= perf_cnt_d;
      end
   end

   assign perf_conflict_cnt = perf_cnt_q;
`endif

   assign gnt_vld   = gnt_vld_q;
   assign gnt_oh    = gnt_oh_q;
   assign gnt_idx   = gnt_idx_q;
   assign entry_vld = entry_vld_q;
   assign empty     = (entry_vld_q == '0);
   assign full      = (entry_vld_q == '1);

endmodule

// File: tb/tb_ct_ciu_age_arb.sv
// Randomized bench for ct_ciu_age_arb against an allocation-order queue model.
module tb_ct_ciu_age_arb;

   localparam int unsigned DEPTH = 24;
   localparam int unsigned IDX_W = 5;

   logic             ciuclk;
   logic             cpurst_b;
   logic             alloc_vld;
   logic [IDX_W-1:0] alloc_idx;
   logic [DEPTH-1:0] dealloc_vec;
   logic [DEPTH-1:0] req_vld;
   logic             gnt_vld;
   logic [DEPTH-1:0] gnt_oh;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_rdy;
   logic [DEPTH-1:0] entry_vld;
   logic             empty;
   logic             full;
`ifdef CT_CIU_AGE_ARB_PERF_EN
   logic [15:0]      perf_conflict_cnt;
`endif

   ct_ciu_age_arb #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_dut (
      .ciuclk      (ciuclk),
      .cpurst_b    (cpurst_b),
      .alloc_vld   (alloc_vld),
      .alloc_idx   (alloc_idx),
      .dealloc_vec (dealloc_vec),
      .req_vld     (req_vld),
      .gnt_vld     (gnt_vld),
      .gnt_oh      (gnt_oh),
      .gnt_idx     (gnt_idx),
      .gnt_rdy     (gnt_rdy),
      .entry_vld   (entry_vld),
      .empty       (empty),
      .full        (full)
`ifdef CT_CIU_AGE_ARB_PERF_EN
      ,
      .perf_conflict_cnt (perf_conflict_cnt)
`endif
   );

   initial ciuclk = 1'b0;
   always #5 ciuclk = ~ciuclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: queue of valid entries, oldest first, plus the held grant.
   int          m_q[$];
   bit          m_gvld;
   int          m_gidx;
   int          m_perf;
   logic [DEPTH-1:0] acc_oh;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [63:0] ev;
      logic [63:0] eoh;
      ev = '0;
      foreach (m_q[k]) ev[m_q[k]] = 1'b1;
      eoh = m_gvld ? (64'd1 << m_gidx) : 64'd0;
      check("gnt_vld",   64'(gnt_vld),   64'(m_gvld));
      check("gnt_idx",   64'(gnt_idx),   m_gvld ? 64'(m_gidx) : 64'd0);
      check("gnt_oh",    64'(gnt_oh),    eoh);
      check("entry_vld", 64'(entry_vld), ev);
      check("empty",     64'(empty),     64'(m_q.size() == 0));
      check("full",      64'(full),      64'(m_q.size() == DEPTH));
`ifdef CT_CIU_AGE_ARB_PERF_EN
      check("perf_cnt",  64'(perf_conflict_cnt), 64'(m_perf));
`endif
   endtask

   // Advance one clock: update the model from the current inputs, then compare after the edge.
   task automatic step();
      int  nq[$];
      int  pick;
      int  ecnt;
      bit  load;
      bit  acc;
      int  acc_i;
      acc   = 1'b0;
      acc_i = 0;
      if (!cpurst_b) begin
         m_q.delete();
         m_gvld = 1'b0;
         m_gidx = 0;
         m_perf = 0;
      end else begin
         pick = -1;
         ecnt = 0;
         foreach (m_q[k]) begin
            if (req_vld[m_q[k]] && !(m_gvld && m_gidx == m_q[k])) begin
               ecnt++;
               if (pick < 0) pick = m_q[k];
            end
         end
         load  = !m_gvld || gnt_rdy;
         acc   = m_gvld && gnt_rdy;
         acc_i = m_gidx;
         if (load && ecnt >= 2 && m_perf < 65535) m_perf++;
         if (load) begin
            m_gvld = (pick >= 0);
            m_gidx = (pick >= 0) ? pick : 0;
         end
         foreach (m_q[k]) begin
            if (!dealloc_vec[m_q[k]] && !(alloc_vld && m_q[k] == int'(alloc_idx)))
               nq.push_back(m_q[k]);
         end
         if (alloc_vld && int'(alloc_idx) < DEPTH) nq.push_back(int'(alloc_idx));
         m_q = nq;
      end
      @(posedge ciuclk);
      #1;
      acc_oh = '0;
      if (acc) begin
         acc_oh[acc_i]  = 1'b1;
         req_vld[acc_i] = 1'b0;
      end
      compare_all();
   endtask

   task automatic do_reset();
      alloc_vld   = 1'b0;
      alloc_idx   = '0;
      dealloc_vec = '0;
      req_vld     = '0;
      gnt_rdy     = 1'b1;
      cpurst_b    = 1'b0;
      step();
      cpurst_b    = 1'b1;
   endtask

   task automatic alloc_one(input int idx);
      alloc_vld = 1'b1;
      alloc_idx = IDX_W'(idx);
      step();
      alloc_vld = 1'b0;
   endtask

   initial begin
      acc_oh = '0;
      m_gvld = 1'b0;
      m_gidx = 0;
      m_perf = 0;

      // Reset state
      do_reset();
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_gvld",  64'(gnt_vld), 64'd0);

      // Grants follow allocation order 3,7,1
      req_vld = '1;
      alloc_one(3);
      alloc_vld = 1'b1; alloc_idx = 5'd7; step();
      check("t1_gnt0", 64'(gnt_idx), 64'd3);
      alloc_vld = 1'b1; alloc_idx = 5'd1; step();
      alloc_vld = 1'b0;
      check("t1_gnt1", 64'(gnt_idx), 64'd7);
      step();
      check("t1_gnt2", 64'(gnt_idx), 64'd1);
      req_vld = '0;
      step();

      // Fill, then realloc 5 with a same-cycle dealloc
      do_reset();
      for (int i = 0; i < DEPTH; i++) alloc_one(i);
      check("t2_full", 64'(full), 64'd1);
      dealloc_vec = '0; dealloc_vec[5] = 1'b1;
      alloc_vld = 1'b1; alloc_idx = 5'd5;
      step();
      alloc_vld = 1'b0; dealloc_vec = '0;
      check("t2_full_hold", 64'(full), 64'd1);
      req_vld = '0; req_vld[5] = 1'b1; req_vld[23] = 1'b1;
      step();
      check("t2_old23", 64'(gnt_idx), 64'd23);
      step();
      check("t2_young5", 64'(gnt_idx), 64'd5);
      req_vld = '0;
      step();

      // Back-pressure holds the grant and masks entry 2
      do_reset();
      alloc_one(2); alloc_one(4); alloc_one(6);
      req_vld = '0; req_vld[2] = 1'b1; req_vld[4] = 1'b1; req_vld[6] = 1'b1;
      gnt_rdy = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         step();
         check("t3_hold_idx", 64'(gnt_idx), 64'd2);
         check("t3_hold_vld", 64'(gnt_vld), 64'd1);
      end
      gnt_rdy = 1'b1;
      step();
      check("t3_next", 64'(gnt_idx), 64'd4);
      req_vld = '0;
      step();

      // Older requester wins once it raises its request
      do_reset();
      alloc_one(0); alloc_one(1); alloc_one(2);
      req_vld = '0; req_vld[2] = 1'b1;
      step();
      check("t4_only2", 64'(gnt_idx), 64'd2);
      step();
      req_vld[0] = 1'b1; req_vld[2] = 1'b1;
      step();
      check("t4_old0", 64'(gnt_idx), 64'd0);
      step();
      check("t4_then2", 64'(gnt_idx), 64'd2);

      // Reset while a grant is pending
      cpurst_b = 1'b0;
      step();
      cpurst_b = 1'b1;
      check("t5_gvld",  64'(gnt_vld), 64'd0);
      check("t5_vld",   64'(entry_vld), 64'd0);
      check("t5_empty", 64'(empty), 64'd1);

      // Randomized traffic; the second phase deallocates rarely so the buffer fills
      for (int c = 0; c < 3000; c++) begin
         int drop_rate;
         drop_rate   = (c < 1500) ? 15 : 120;
         alloc_vld   = ($urandom_range(0, 3) != 0);
         alloc_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
         dealloc_vec = '0;
         for (int j = 0; j < DEPTH; j++)
            if ($urandom_range(0, drop_rate) == 0) dealloc_vec[j] = 1'b1;
         req_vld     = DEPTH'($urandom) & ~acc_oh;
         gnt_rdy     = ($urandom_range(0, 2) != 0);
         cpurst_b    = ($urandom_range(0, 700) != 0);
         step();
         cpurst_b    = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
